// File: rtl/ntt_bf_writeback_unit_pkg.sv
// Shared NTT definitions: bank count, crossbar select codes,
// and the write-back conflict helper.
package ntt_bf_writeback_unit_pkg;

   localparam int NUM_BANKS = 8;
   localparam int SEL_W     = 3;
   localparam int WBC_W     = 16;

   typedef logic [SEL_W-1:0] sel_t;

   // Select codes are shared with the read-side crossbar.
   // The write side applies them in the inverse direction.
   localparam sel_t SEL_X0 = 3'b000;
   localparam sel_t SEL_Y0 = 3'b001;
   localparam sel_t SEL_X1 = 3'b010;
   localparam sel_t SEL_Y1 = 3'b011;
   localparam sel_t SEL_X2 = 3'b100;
   localparam sel_t SEL_Y2 = 3'b101;
   localparam sel_t SEL_X3 = 3'b110;
   localparam sel_t SEL_Y3 = 3'b111;

   // Two enabled banks that take the same butterfly output.
   function automatic logic sel_conflict(
      input logic [NUM_BANKS-1:0][SEL_W-1:0] sel,
      input logic [NUM_BANKS-1:0]            mask
   );
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         for (int j = i + 1; j < NUM_BANKS; j++) begin
            if (mask[i] && mask[j] && (sel[i] == sel[j])) begin
               hit = 1'b1;
            end
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/ntt_bf_writeback_unit_if.sv
// Bundle between the butterfly controller and the write-back unit.
// The controller side is master; the write-back unit is slave.
interface ntt_bf_writeback_unit_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 10
);
   import ntt_bf_writeback_unit_pkg::*;

   logic                  issue_valid;
   sel_t                  sel_b_0;
   sel_t                  sel_b_1;
   sel_t                  sel_b_2;
   sel_t                  sel_b_3;
   sel_t                  sel_b_4;
   sel_t                  sel_b_5;
   sel_t                  sel_b_6;
   sel_t                  sel_b_7;
   logic [NUM_BANKS-1:0]  bank_mask;
   logic [ADDR_WIDTH-1:0] waddr_0;
   logic [ADDR_WIDTH-1:0] waddr_1;
   logic [ADDR_WIDTH-1:0] waddr_2;
   logic [ADDR_WIDTH-1:0] waddr_3;
   logic [ADDR_WIDTH-1:0] waddr_4;
   logic [ADDR_WIDTH-1:0] waddr_5;
   logic [ADDR_WIDTH-1:0] waddr_6;
   logic [ADDR_WIDTH-1:0] waddr_7;
   logic [DATA_WIDTH-1:0] x0;
   logic [DATA_WIDTH-1:0] y0;
   logic [DATA_WIDTH-1:0] x1;
   logic [DATA_WIDTH-1:0] y1;
   logic [DATA_WIDTH-1:0] x2;
   logic [DATA_WIDTH-1:0] y2;
   logic [DATA_WIDTH-1:0] x3;
   logic [DATA_WIDTH-1:0] y3;
   logic                  flush;
   logic                  clr_err;

   logic [DATA_WIDTH-1:0] d0;
   logic [DATA_WIDTH-1:0] d1;
   logic [DATA_WIDTH-1:0] d2;
   logic [DATA_WIDTH-1:0] d3;
   logic [DATA_WIDTH-1:0] d4;
   logic [DATA_WIDTH-1:0] d5;
   logic [DATA_WIDTH-1:0] d6;
   logic [DATA_WIDTH-1:0] d7;
   logic [ADDR_WIDTH-1:0] a0;
   logic [ADDR_WIDTH-1:0] a1;
   logic [ADDR_WIDTH-1:0] a2;
   logic [ADDR_WIDTH-1:0] a3;
   logic [ADDR_WIDTH-1:0] a4;
   logic [ADDR_WIDTH-1:0] a5;
   logic [ADDR_WIDTH-1:0] a6;
   logic [ADDR_WIDTH-1:0] a7;
   logic [NUM_BANKS-1:0]  we;
   logic                  busy;
   logic                  conflict;
   logic [WBC_W-1:0]      wb_count;

   modport master (
      output issue_valid,
      output sel_b_0, sel_b_1, sel_b_2, sel_b_3,
      output sel_b_4, sel_b_5, sel_b_6, sel_b_7,
      output bank_mask,
      output waddr_0, waddr_1, waddr_2, waddr_3,
      output waddr_4, waddr_5, waddr_6, waddr_7,
      output x0, y0, x1, y1, x2, y2, x3, y3,
      output flush, clr_err,
      input  d0, d1, d2, d3, d4, d5, d6, d7,
      input  a0, a1, a2, a3, a4, a5, a6, a7,
      input  we, busy, conflict, wb_count
   );

   modport slave (
      input  issue_valid,
      input  sel_b_0, sel_b_1, sel_b_2, sel_b_3,
      input  sel_b_4, sel_b_5, sel_b_6, sel_b_7,
      input  bank_mask,
      input  waddr_0, waddr_1, waddr_2, waddr_3,
      input  waddr_4, waddr_5, waddr_6, waddr_7,
      input  x0, y0, x1, y1, x2, y2, x3, y3,
      input  flush, clr_err,
      output d0, d1, d2, d3, d4, d5, d6, d7,
      output a0, a1, a2, a3, a4, a5, a6, a7,
      output we, busy, conflict, wb_count
   );

endinterface

// File: rtl/ntt_ctrl_delay_line.sv
// Fixed-depth control shift register with synchronous clear.
// Bit 0 of each word is its valid flag, exposed per stage.
module ntt_ctrl_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [DEPTH-1:0] vld_taps
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   // Shift one word per cycle; clear drops everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else if (clr) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= din;
         for (int k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

   // Per-stage valid flags for occupancy reporting.
   always_comb begin
      vld_taps = '0;
      for (int k = 0; k < DEPTH; k++) begin
         vld_taps[k] = stage_q[k][0];
      end
   end

endmodule

// File: rtl/ntt_bf_writeback_unit.sv
// Butterfly write-back: delays each descriptor to meet its
// butterfly results, then routes results to the bank write ports.
module ntt_bf_writeback_unit
   import ntt_bf_writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 10,
   parameter int BF_LATENCY = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   ntt_bf_writeback_unit_if.slave  bus
);

   localparam int DESC_W = 1 + NUM_BANKS * SEL_W
                         + NUM_BANKS + NUM_BANKS * ADDR_WIDTH;

   logic [NUM_BANKS-1:0][SEL_W-1:0]      sel_in;
   logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] waddr_in;
   logic [DESC_W-1:0]                    desc_in;
   logic [DESC_W-1:0]                    desc_o;
   logic [BF_LATENCY-1:0]                vld_taps;

   logic [NUM_BANKS-1:0][SEL_W-1:0]      sel_o;
   logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] waddr_o;
   logic [NUM_BANKS-1:0]                 mask_o;
   logic                                 valid_o;
   logic                                 emerge;

   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] dnext;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] d_q;
   logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] a_q;
   logic [NUM_BANKS-1:0]                 we_q;
   logic                                 conflict_q;
   logic [WBC_W-1:0]                     cnt_q;

   assign sel_in = {bus.sel_b_7, bus.sel_b_6,
                    bus.sel_b_5, bus.sel_b_4,
                    bus.sel_b_3, bus.sel_b_2,
                    bus.sel_b_1, bus.sel_b_0};

   assign waddr_in = {bus.waddr_7, bus.waddr_6,
                      bus.waddr_5, bus.waddr_4,
                      bus.waddr_3, bus.waddr_2,
                      bus.waddr_1, bus.waddr_0};

   // Valid sits in bit 0 so the delay line can report occupancy.
   assign desc_in = {waddr_in, bus.bank_mask,
                     sel_in, bus.issue_valid};

   ntt_ctrl_delay_line #(
      .WIDTH (DESC_W),
      .DEPTH (BF_LATENCY)
   ) u_dly (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.flush),
      .din      (desc_in),
      .dout     (desc_o),
      .vld_taps (vld_taps)
   );

   assign {waddr_o, mask_o, sel_o, valid_o} = desc_o;

   // A descriptor leaving the line in a flush cycle is dropped too.
   assign emerge = valid_o & ~bus.flush;

   assign bus.busy = |vld_taps;

   // Route each bank to the butterfly output named by its select.
   always_comb begin
      dnext = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         unique case (sel_o[k])
            SEL_X0: dnext[k] = bus.x0;
            SEL_Y0: dnext[k] = bus.y0;
            SEL_X1: dnext[k] = bus.x1;
            SEL_Y1: dnext[k] = bus.y1;
            SEL_X2: dnext[k] = bus.x2;
            SEL_Y2: dnext[k] = bus.y2;
            SEL_X3: dnext[k] = bus.x3;
            SEL_Y3: dnext[k] = bus.y3;
         endcase
      end
   end

   // Register bank writes; disabled banks keep their last data/address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q <= '0;
         d_q  <= '0;
         a_q  <= '0;
      end else begin
         we_q <= emerge ? mask_o : '0;
         for (int k = 0; k < NUM_BANKS; k++) begin
            if (emerge && mask_o[k]) begin
               d_q[k] <= dnext[k];
               a_q[k] <= waddr_o[k];
            end
         end
      end
   end

   // Sticky conflict; a fresh conflict outranks clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_q <= 1'b0;
      end else if (emerge && sel_conflict(sel_o, mask_o)) begin
         conflict_q <= 1'b1;
      end else if (bus.clr_err) begin
         conflict_q <= 1'b0;
      end
   end

   // Count beats that actually wrote something; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (emerge && (|mask_o)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.we       = we_q;
   assign bus.conflict = conflict_q;
   assign bus.wb_count = cnt_q;

   assign bus.d0 = d_q[0];
   assign bus.d1 = d_q[1];
   assign bus.d2 = d_q[2];
   assign bus.d3 = d_q[3];
   assign bus.d4 = d_q[4];
   assign bus.d5 = d_q[5];
   assign bus.d6 = d_q[6];
   assign bus.d7 = d_q[7];

   assign bus.a0 = a_q[0];
   assign bus.a1 = a_q[1];
   assign bus.a2 = a_q[2];
   assign bus.a3 = a_q[3];
   assign bus.a4 = a_q[4];
   assign bus.a5 = a_q[5];
   assign bus.a6 = a_q[6];
   assign bus.a7 = a_q[7];

endmodule

// File: tb/tb_ntt_bf_writeback_unit.sv
// Directed bench for the butterfly write-back unit.
// Expected values are hand-derived from issue timing and select codes.
module tb_ntt_bf_writeback_unit;

   localparam int DW = 256;
   localparam int AW = 10;
   localparam int LAT = 8;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   ntt_bf_writeback_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ntt_bf_writeback_unit #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BF_LATENCY (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] get_d(input int k);
      case (k)
         0: return bus.d0;
         1: return bus.d1;
         2: return bus.d2;
         3: return bus.d3;
         4: return bus.d4;
         5: return bus.d5;
         6: return bus.d6;
         default: return bus.d7;
      endcase
   endfunction

   function automatic logic [255:0] get_a(input int k);
      case (k)
         0: return 256'(bus.a0);
         1: return 256'(bus.a1);
         2: return 256'(bus.a2);
         3: return 256'(bus.a3);
         4: return 256'(bus.a4);
         5: return 256'(bus.a5);
         6: return 256'(bus.a6);
         default: return 256'(bus.a7);
      endcase
   endfunction

   // x0..y3 = base+1..base+8, so sel code s yields base+s+1.
   task automatic set_xy(input int base);
      bus.x0 = DW'(base + 1);
      bus.y0 = DW'(base + 2);
      bus.x1 = DW'(base + 3);
      bus.y1 = DW'(base + 4);
      bus.x2 = DW'(base + 5);
      bus.y2 = DW'(base + 6);
      bus.x3 = DW'(base + 7);
      bus.y3 = DW'(base + 8);
   endtask

   // Bank k takes sel code k and address abase+k.
   task automatic issue_ident(input logic [7:0] m, input int abase);
      bus.issue_valid = 1'b1;
      bus.bank_mask = m;
      bus.sel_b_0 = 3'd0;
      bus.sel_b_1 = 3'd1;
      bus.sel_b_2 = 3'd2;
      bus.sel_b_3 = 3'd3;
      bus.sel_b_4 = 3'd4;
      bus.sel_b_5 = 3'd5;
      bus.sel_b_6 = 3'd6;
      bus.sel_b_7 = 3'd7;
      bus.waddr_0 = AW'(abase + 0);
      bus.waddr_1 = AW'(abase + 1);
      bus.waddr_2 = AW'(abase + 2);
      bus.waddr_3 = AW'(abase + 3);
      bus.waddr_4 = AW'(abase + 4);
      bus.waddr_5 = AW'(abase + 5);
      bus.waddr_6 = AW'(abase + 6);
      bus.waddr_7 = AW'(abase + 7);
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
      bus.bank_mask = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      issue_ident(8'h00, 0);
      idle();
      bus.flush = 1'b0;
      bus.clr_err = 1'b0;
      set_xy(0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      do_reset();

      // Reset state
      chk("rst_we", 256'(bus.we), 256'h0);
      chk("rst_busy", 256'(bus.busy), 256'h0);
      chk("rst_conflict", 256'(bus.conflict), 256'h0);
      chk("rst_wbcount", 256'(bus.wb_count), 256'h0);
      chk("rst_d0", bus.d0, 256'h0);
      chk("rst_a7", 256'(bus.a7), 256'h0);

      // Single descriptor: issue at 0, data at 8, write visible at 9
      issue_ident(8'hFF, 0);
      tick();
      chk("t1_busy", 256'(bus.busy), 256'h1);
      idle();
      repeat (LAT - 1) tick();
      chk("t1_we_early", 256'(bus.we), 256'h0);
      set_xy(0);
      tick();
      chk("t1_we", 256'(bus.we), 256'hFF);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t1_d%0d", k), get_d(k), 256'(k + 1));
         chk($sformatf("t1_a%0d", k), get_a(k), 256'(k));
      end
      chk("t1_wbcount", 256'(bus.wb_count), 256'h1);
      chk("t1_conflict", 256'(bus.conflict), 256'h0);
      chk("t1_busy_done", 256'(bus.busy), 256'h0);
      set_xy(100);
      tick();
      chk("t1_we_after", 256'(bus.we), 256'h0);
      chk("t1_d3_hold", bus.d3, 256'h4);

      // Valid descriptor with empty mask writes nothing, counts nothing
      issue_ident(8'h00, 0);
      tick();
      idle();
      repeat (LAT) tick();
      chk("m0_we", 256'(bus.we), 256'h0);
      chk("m0_wbcount", 256'(bus.wb_count), 256'h1);

      // 16 back-to-back issues; data at cycle c carries base 16*c
      do_reset();
      for (int c = 0; c < 25; c++) begin
         if (c < 16) issue_ident(8'hFF, 8 * c);
         else idle();
         set_xy(16 * c);
         tick();
         if (c >= LAT && c < LAT + 16) begin
            chk($sformatf("bb_we_%0d", c), 256'(bus.we), 256'hFF);
            chk($sformatf("bb_a0_%0d", c), get_a(0), 256'(8 * (c - LAT)));
            chk($sformatf("bb_a7_%0d", c), get_a(7), 256'(8 * (c - LAT) + 7));
            chk($sformatf("bb_d0_%0d", c), get_d(0), 256'(16 * c + 1));
            chk($sformatf("bb_d5_%0d", c), get_d(5), 256'(16 * c + 6));
         end else begin
            chk($sformatf("bb_we_%0d", c), 256'(bus.we), 256'h0);
         end
      end
      chk("bb_wbcount", 256'(bus.wb_count), 256'd16);

      // Reset mid-stream: outputs clear at once, nothing emerges later
      issue_ident(8'hFF, 0);
      set_xy(7);
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("mr_we", 256'(bus.we), 256'h0);
      chk("mr_d0", bus.d0, 256'h0);
      chk("mr_a7", 256'(bus.a7), 256'h0);
      chk("mr_wbcount", 256'(bus.wb_count), 256'h0);
      chk("mr_busy", 256'(bus.busy), 256'h0);
      chk("mr_conflict", 256'(bus.conflict), 256'h0);
      tick();
      rst = 1'b0;
      idle();
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("mr_we_post%0d", c), 256'(bus.we), 256'h0);
      end
      chk("mr_wbcount_post", 256'(bus.wb_count), 256'h0);

      // Conflict: banks 0 and 7 both take y1
      do_reset();
      issue_ident(8'h81, 'h3A0);
      bus.sel_b_0 = 3'b011;
      bus.sel_b_7 = 3'b011;
      tick();
      idle();
      repeat (LAT - 1) tick();
      chk("cf_pre", 256'(bus.conflict), 256'h0);
      set_xy('h50);
      tick();
      chk("cf_we", 256'(bus.we), 256'h81);
      chk("cf_d0", bus.d0, 256'h54);
      chk("cf_d7", bus.d7, 256'h54);
      chk("cf_d1_hold", bus.d1, 256'h0);
      chk("cf_a0", 256'(bus.a0), 256'h3A0);
      chk("cf_a7", 256'(bus.a7), 256'h3A7);
      chk("cf_flag", 256'(bus.conflict), 256'h1);
      tick();
      chk("cf_sticky", 256'(bus.conflict), 256'h1);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("cf_cleared", 256'(bus.conflict), 256'h0);

      // Duplicate select on a masked-off bank is not a conflict
      issue_ident(8'h01, 0);
      bus.sel_b_0 = 3'b011;
      bus.sel_b_1 = 3'b011;
      tick();
      idle();
      repeat (LAT) tick();
      chk("nc_we", 256'(bus.we), 256'h01);
      chk("nc_flag", 256'(bus.conflict), 256'h0);

      // New conflict in the same cycle as clr_err keeps the flag set
      issue_ident(8'h81, 0);
      bus.sel_b_0 = 3'b011;
      bus.sel_b_7 = 3'b011;
      tick();
      idle();
      repeat (LAT - 1) tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("cc_flag", 256'(bus.conflict), 256'h1);
      chk("cc_wbcount", 256'(bus.wb_count), 256'd3);

      // Flush with three in flight plus one issued in the flush cycle
      issue_ident(8'hFF, 0);
      tick();
      tick();
      tick();
      chk("fl_busy_pre", 256'(bus.busy), 256'h1);
      idle();
      tick();
      issue_ident(8'hFF, 0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      idle();
      chk("fl_busy", 256'(bus.busy), 256'h0);
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("fl_we_%0d", c), 256'(bus.we), 256'h0);
      end

      // Flush in the cycle a descriptor emerges suppresses its write
      issue_ident(8'hFF, 0);
      tick();
      idle();
      repeat (LAT - 1) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fe_we", 256'(bus.we), 256'h0);
      chk("fe_busy", 256'(bus.busy), 256'h0);
      chk("fe_wbcount", 256'(bus.wb_count), 256'd3);
      chk("fe_conflict", 256'(bus.conflict), 256'h1);

      // Counter wrap after 65535 beats
      do_reset();
      issue_ident(8'hFF, 0);
      repeat (65535) tick();
      idle();
      repeat (LAT) tick();
      chk("wr_full", 256'(bus.wb_count), 256'hFFFF);
      chk("wr_busy", 256'(bus.busy), 256'h0);
      issue_ident(8'hFF, 0);
      tick();
      idle();
      repeat (LAT) tick();
      chk("wr_we", 256'(bus.we), 256'hFF);
      chk("wr_wrap", 256'(bus.wb_count), 256'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
